// File: rtl/regfile_pkg.sv
// Shared sizing defaults and FSM state type for the register-file dump sequencer.
package regfile_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned ADDR_WIDTH_DEF = 5;
  localparam int unsigned REG_COUNT      = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/regfile_addr_counter.sv
// Loadable, wrapping read-address counter with an end-of-range compare.
module regfile_addr_counter #(
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  inc,
  input  logic [ADDR_WIDTH-1:0] load_val,
  input  logic [ADDR_WIDTH-1:0] last,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  at_last
);

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  always_comb begin
    addr_d = addr_q;
    if (load) begin
      addr_d = load_val;
    end else if (inc) begin
      addr_d = addr_q + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr    = addr_q;
  assign at_last = (addr_q == last);

endmodule

// File: rtl/regfile_dump.sv
// Read-side dump sequencer: walks FirstReg..LastReg (wrapping) and streams words out on valid/ready.
// Optional XOR checksum output enabled by defining REGFILE_DUMP_CHECKSUM_EN.
module regfile_dump
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  Start,
  input  logic [ADDR_WIDTH-1:0] FirstReg,
  input  logic [ADDR_WIDTH-1:0] LastReg,
  output logic [ADDR_WIDTH-1:0] ReadRegister,
  input  logic [DATA_WIDTH-1:0] ReadData,
  output logic [DATA_WIDTH-1:0] DumpData,
  output logic [ADDR_WIDTH-1:0] DumpAddr,
  output logic                  DumpValid,
  input  logic                  DumpReady,
  output logic                  DumpLast,
  output logic                  Busy,
  output logic                  Done
`ifdef REGFILE_DUMP_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] Checksum
`endif
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] last_q, last_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  valid_q, valid_d;
  logic                  lastflag_q, lastflag_d;
  logic                  cnt_load, cnt_inc, cnt_at_last;

  regfile_addr_counter #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr_counter (
    .clk     (Clk),
    .rst_n   (Reset_n),
    .load    (cnt_load),
    .inc     (cnt_inc),
    .load_val(FirstReg),
    .last    (last_q),
    .addr    (ReadRegister),
    .at_last (cnt_at_last)
  );

`ifdef REGFILE_DUMP_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] chk_q, chk_d;
`endif

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    data_d     = data_q;
    addr_d     = addr_q;
    valid_d    = valid_q;
    lastflag_d = lastflag_q;
    cnt_load   = 1'b0;
    cnt_inc    = 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    chk_d      = chk_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          last_d   = LastReg;
          cnt_load = 1'b1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
          chk_d    = '0;
`endif
          state_d  = LOAD;
        end
      end
      LOAD: begin
        data_d     = ReadData;
        addr_d     = ReadRegister;
        valid_d    = 1'b1;
        lastflag_d = cnt_at_last;
        state_d    = SEND;
      end
      SEND: begin
        // Address advances only on accept, so ReadData always gets a full LOAD cycle.
        if (DumpReady) begin
          valid_d = 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
          chk_d   = chk_q ^ data_q;
`endif
          if (lastflag_q) begin
            state_d = DONE;
          end else begin
            cnt_inc = 1'b1;
            state_d = LOAD;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      last_q     <= '0;
      data_q     <= '0;
      addr_q     <= '0;
      valid_q    <= 1'b0;
      lastflag_q <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      chk_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
      valid_q    <= valid_d;
      lastflag_q <= lastflag_d;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      chk_q      <= chk_d;
`endif
    end
  end

  assign DumpData  = data_q;
  assign DumpAddr  = addr_q;
  assign DumpValid = valid_q;
  assign DumpLast  = lastflag_q;
  assign Busy      = (state_q == LOAD) || (state_q == SEND);
  assign Done      = (state_q == DONE);
`ifdef REGFILE_DUMP_CHECKSUM_EN
  assign Checksum  = chk_q;
`endif

endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump with a behavioural register file and dump-order model.
module tb_regfile_dump;

  logic        Clk;
  logic        Reset_n;
  logic        Start;
  logic [4:0]  FirstReg, LastReg, ReadRegister, DumpAddr;
  logic [31:0] ReadData, DumpData;
  logic        DumpValid, DumpReady, DumpLast, Busy, Done;
`ifdef REGFILE_DUMP_CHECKSUM_EN
  logic [31:0] Checksum;
`endif

  logic [31:0] regs [32];
  int unsigned n_tests;
  int unsigned n_fail;

  regfile_dump #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(5)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .Start       (Start),
    .FirstReg    (FirstReg),
    .LastReg     (LastReg),
    .ReadRegister(ReadRegister),
    .ReadData    (ReadData),
    .DumpData    (DumpData),
    .DumpAddr    (DumpAddr),
    .DumpValid   (DumpValid),
    .DumpReady   (DumpReady),
    .DumpLast    (DumpLast),
    .Busy        (Busy),
    .Done        (Done)
`ifdef REGFILE_DUMP_CHECKSUM_EN
    ,
    .Checksum    (Checksum)
`endif
  );

  assign ReadData = regs[ReadRegister];

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [4:0] a);
    return (a == 5'd0) ? 32'h0 : (32'hA000_0000 + 32'(a));
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_rdreg"}, 32'(ReadRegister), 32'h0);
    check({tag, "_data"},  DumpData, 32'h0);
    check({tag, "_addr"},  32'(DumpAddr), 32'h0);
    check({tag, "_valid"}, 32'(DumpValid), 32'h0);
    check({tag, "_last"},  32'(DumpLast), 32'h0);
    check({tag, "_busy"},  32'(Busy), 32'h0);
    check({tag, "_done"},  32'(Done), 32'h0);
  endtask

  // mode: 0 = always ready, 1 = 3 stall cycles per word, 2 = random 0..2 stalls
  task automatic do_dump(input logic [4:0] f, input logic [4:0] l,
                         input int unsigned mode, input bit poke_start);
    int unsigned n, cyc, got_n, dones, waitc, last_acc;
    bit          stalled;
    logic [31:0] hd, xr;
    logic [4:0]  ha, ea;
    n = ((32'(l) + 32 - 32'(f)) % 32) + 1;
    cyc = 0; got_n = 0; dones = 0; waitc = 0; last_acc = 0; stalled = 0;
    hd = '0; ha = '0; xr = '0;
    @(negedge Clk);
    FirstReg = f; LastReg = l; Start = 1'b1; DumpReady = 1'b0;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    FirstReg = 5'($urandom);
    LastReg  = 5'($urandom);
    while (cyc < 400 && dones == 0) begin
      @(negedge Clk);
      cyc++;
      if (poke_start && cyc == 1) begin
        check("busy_during_dump", 32'(Busy), 32'h1);
        Start = 1'b1;
      end else begin
        Start = 1'b0;
      end
      if (Done) begin
        dones++;
        check("word_count", got_n, n);
`ifdef REGFILE_DUMP_CHECKSUM_EN
        check("checksum", Checksum, xr);
`endif
      end else if (DumpValid) begin
        if (stalled) begin
          check("stall_data", DumpData, hd);
          check("stall_addr", 32'(DumpAddr), 32'(ha));
        end else begin
          waitc = (mode == 0) ? 0 : (mode == 1) ? 3 : $urandom_range(0, 2);
        end
        if (waitc > 0) begin
          DumpReady = 1'b0;
          waitc--;
          stalled = 1'b1;
          hd = DumpData;
          ha = DumpAddr;
        end else begin
          DumpReady = 1'b1;
          stalled = 1'b0;
          ea = f + 5'(got_n);
          check("addr", 32'(DumpAddr), 32'(ea));
          check("data", DumpData, exp_word(ea));
          check("last", 32'(DumpLast), 32'(got_n == n - 1));
          xr ^= exp_word(ea);
          got_n++;
          last_acc = cyc;
        end
      end
    end
    Start = 1'b0;
    check("done_seen", dones, 1);
    if (mode == 0 && n == 32) check("full_latency", last_acc, 64);
    @(negedge Clk);
    check("done_one_pulse", 32'(Done), 32'h0);
    check("idle_valid", 32'(DumpValid), 32'h0);
    check("idle_busy", 32'(Busy), 32'h0);
`ifdef REGFILE_DUMP_CHECKSUM_EN
    check("checksum_hold", Checksum, xr);
`endif
  endtask

  task automatic reset_mid_dump();
    int unsigned acc;
    bit          hit;
    acc = 0; hit = 0;
    @(negedge Clk);
    FirstReg = 5'd0; LastReg = 5'd10; Start = 1'b1; DumpReady = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge Clk);
      if (DumpValid) begin
        if (acc == 2) begin
          hit = 1'b1;
        end else begin
          acc++;
        end
      end
    end
    check("reset_reached_word3", 32'(hit), 32'h1);
    DumpReady = 1'b0;
    #2;
    Reset_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge Clk);
    Reset_n = 1'b1;
    do_dump(5'd4, 5'd6, 0, 1'b0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int k = 0; k < 32; k++) regs[k] = (k == 0) ? 32'h0 : 32'hA000_0000 + 32'(k);
    Reset_n = 1'b0; Start = 1'b0; DumpReady = 1'b0; FirstReg = '0; LastReg = '0;
    #12;
    check_all_zero("reset");
    @(negedge Clk);
    Reset_n = 1'b1;

    do_dump(5'd0,  5'd31, 0, 1'b0);
    do_dump(5'd5,  5'd7,  1, 1'b0);
    do_dump(5'd30, 5'd1,  0, 1'b0);
    do_dump(5'd9,  5'd9,  0, 1'b1);
    do_dump(5'd1,  5'd3,  0, 1'b0);
    reset_mid_dump();
    for (int t = 0; t < 6; t++) begin
      do_dump(5'($urandom), 5'($urandom), 2, 1'(t % 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
